lenet_frame_reader: RTL

- Reader side of the LeNet input buffer filled by the camera core. The buffer is a 32x32 8-bit BRAM image, and the core writes the 28x28 downsampled pixels at address 66 + x + 32*y.
- On the core's data_ready pulse, this block scans the full 32x32 frame in raster order through the BRAM read port.
- It forces the 2-pixel border to PAD_VALUE and streams pixels to the CNN over a valid/ready interface with first/last markers.
- A 2-entry output buffer absorbs the 1-cycle BRAM latency under backpressure.

---
 rtl/lenet_frame_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lenet_frame_reader.sv
// Reads the 32x32 LeNet input buffer in raster order, forces the border to PAD_VALUE and
// streams the pixels over valid/ready with first/last markers.
module lenet_frame_reader #(
  parameter int IMG_SIZE  = 32,
  parameter int PAD       = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int PAD_VALUE = 0
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_first,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int N     = IMG_SIZE * IMG_SIZE;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] PAD_DATA = DATA_W'(PAD_VALUE);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              infl;
  logic              infl_pad, infl_first, infl_last;
  logic [DATA_W-1:0] buf_data  [2];
  logic              buf_first [2];
  logic              buf_last  [2];
  logic              wptr, rptr;
  logic [1:0]        occ;

  logic              pop, last_hs;
  logic [2:0]        pend, limit;
  int                row, col;
  logic              iss_pad, iss_first, iss_last;

  assign pop     = m_valid & m_ready;
  assign last_hs = pop & m_last;

  // A pop in the same cycle frees a slot, so issue can continue at one beat per cycle.
  assign pend  = {1'b0, occ} + {2'b0, infl};
  assign limit = 3'd2 + {2'b0, pop};
  assign rd_en   = (state == STREAM) && (cnt < CNT_W'(N)) && (pend < limit);
  assign rd_addr = cnt[ADDR_W-1:0];

  always_comb begin
    row       = int'(cnt) / IMG_SIZE;
    col       = int'(cnt) % IMG_SIZE;
    iss_pad   = (row < PAD) || (row >= IMG_SIZE - PAD) || (col < PAD) || (col >= IMG_SIZE - PAD);
    iss_first = (cnt == '0);
    iss_last  = (cnt == CNT_W'(N - 1));
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? buf_data[rptr]  : '0;
  assign m_first = m_valid ? buf_first[rptr] : 1'b0;
  assign m_last  = m_valid ? buf_last[rptr]  : 1'b0;

  // Control: frame state, issue counter, read-in-flight flag and FIFO pointers.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      infl    <= 1'b0;
      occ     <= 2'd0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (rd_en) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        STREAM: begin
          if (start) overrun <= 1'b1;
          if (last_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      infl <= rd_en;
      if (infl) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
    end
  end

  // Data: read tags travel with the in-flight read, then land in the FIFO with the BRAM word.
  always_ff @(posedge clk25) begin
    if (rd_en) begin
      infl_pad   <= iss_pad;
      infl_first <= iss_first;
      infl_last  <= iss_last;
    end
    if (infl) begin
      buf_data[wptr]  <= infl_pad ? PAD_DATA : rd_data;
      buf_first[wptr] <= infl_first;
      buf_last[wptr]  <= infl_last;
    end
  end

endmodule
